// File: rtl/sobel_filter_pkg.sv
// Shared definitions for the Sobel edge-detector stage: FSM state encoding,
// kernel weights and the mapping from 3x3 window position to shift-register tap.
package sobel_filter_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,   // priming the line buffer, no output yet
        S_RUN   = 2'd1,   // one input pixel in, one result out
        S_FLUSH = 2'd2    // draining the last IMG_WIDTH+1 results with zero fill
    } sobel_state_e;

    // 1-2-1 smoothing weights applied across the derivative direction.
    localparam int unsigned SOBEL_EDGE_WEIGHT = 1;
    localparam int unsigned SOBEL_MID_WEIGHT  = 2;

    // Tap index for window row r (0 = oldest line) and column c (0 = leftmost),
    // given a line length of w pixels. Tap 0 holds the newest pixel.
    function automatic int unsigned window_tap(input int unsigned w,
                                               input int unsigned r,
                                               input int unsigned c);
        return (2 - r) * w + (2 - c);
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator: gradient magnitude |Gx|+|Gy| followed by
// either saturation to W bits (THRESHOLD=0) or a binary threshold.
module sobel_kernel
    import sobel_filter_pkg::*;
#(
    parameter int W         = 8,
    parameter int THRESHOLD = 0
) (
    input  logic [8:0][W-1:0] win,     // win[3*row+col], row 0 = top
    output logic [W-1:0]      result
);

    localparam int SW = W + 4;
    typedef logic signed [SW-1:0] acc_t;

    localparam acc_t          EDGE    = acc_t'(SOBEL_EDGE_WEIGHT);
    localparam acc_t          MID     = acc_t'(SOBEL_MID_WEIGHT);
    localparam logic [W+2:0]  MAG_MAX = {3'b000, {W{1'b1}}};
    localparam logic [W+2:0]  THR     = THRESHOLD[W+2:0];

    function automatic acc_t ext(input logic [W-1:0] p);
        return acc_t'({4'b0000, p});
    endfunction

    acc_t          left_sum, right_sum, top_sum, bottom_sum;
    acc_t          gx, gy;
    logic [SW-1:0] abs_gx, abs_gy;
    logic [W+2:0]  mag;

    // The centre pixel and the sign bit of the absolute values carry no information.
    logic unused_bits;
    assign unused_bits = ^{win[4], abs_gx[SW-1], abs_gy[SW-1]};

    // Gradients, magnitude and output mapping.
    always_comb begin
        left_sum   = EDGE * ext(win[0]) + MID * ext(win[3]) + EDGE * ext(win[6]);
        right_sum  = EDGE * ext(win[2]) + MID * ext(win[5]) + EDGE * ext(win[8]);
        top_sum    = EDGE * ext(win[0]) + MID * ext(win[1]) + EDGE * ext(win[2]);
        bottom_sum = EDGE * ext(win[6]) + MID * ext(win[7]) + EDGE * ext(win[8]);
        gx         = right_sum - left_sum;
        gy         = bottom_sum - top_sum;
        abs_gx     = gx[SW-1] ? -gx : gx;
        abs_gy     = gy[SW-1] ? -gy : gy;
        mag        = abs_gx[W+2:0] + abs_gy[W+2:0];
        if (THRESHOLD == 0) begin
            result = (mag > MAG_MAX) ? '1 : mag[W-1:0];
        end else begin
            result = (mag >= THR) ? '1 : '0;
        end
    end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge detector between two FIFOs. Raster-order pixels are
// shifted into a two-line-plus-three-pixel buffer; one result is produced per
// input pixel, border pixels forced to zero, with a zero-fill flush at frame end.
module sobel_filter
    import sobel_filter_pkg::*;
#(
    parameter int FIFO_DWIDTH = 8,
    parameter int IMG_WIDTH   = 720,
    parameter int IMG_HEIGHT  = 540,
    parameter int THRESHOLD   = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   fifo_in_rd_en,
    input  logic [FIFO_DWIDTH-1:0] fifo_in_dout,
    input  logic                   fifo_in_empty,
    output logic                   fifo_out_wr_en,
    output logic [FIFO_DWIDTH-1:0] fifo_out_din,
    input  logic                   fifo_out_full
);

    localparam int W      = FIFO_DWIDTH;
    localparam int SR_LEN = 2 * IMG_WIDTH + 3;
    localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW     = $clog2(NPIX);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int FW     = $clog2(IMG_WIDTH + 1);

    localparam logic [PW-1:0] FILL_LAST  = PW'(IMG_WIDTH);
    localparam logic [PW-1:0] PIX_LAST   = PW'(NPIX - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

    sobel_state_e               state_q, state_d;
    logic [PW-1:0]              in_cnt_q, in_cnt_d;       // index of next pixel read
    logic [FW-1:0]              flush_cnt_q, flush_cnt_d; // loads done in S_FLUSH
    logic [CW-1:0]              col_q, col_d;             // centre of next result
    logic [RW-1:0]              row_q, row_d;
    logic [SR_LEN-1:0][W-1:0]   sr_q, sr_d;
    logic                       out_valid_q, out_valid_d;
    logic [W-1:0]               out_data_q, out_data_d;

    logic                       adv, shift_en, load, border;
    logic [W-1:0]               pixel_in, kernel_result;
    logic [SR_LEN-1:0][W-1:0]   sr_shift;
    logic [8:0][W-1:0]          win;

    // The oldest tap is shifted out without ever being part of a window.
    logic unused_oldest;
    assign unused_oldest = ^sr_q[SR_LEN-1];

    // Handshake: reads stall on empty input or a blocked output register;
    // nothing moves while reset is asserted so no upstream pixel is lost.
    always_comb begin
        adv            = ~out_valid_q | ~fifo_out_full;
        fifo_in_rd_en  = ~reset & ~fifo_in_empty &
                         ((state_q == S_FILL) | ((state_q == S_RUN) & adv));
        fifo_out_wr_en = ~reset & out_valid_q & ~fifo_out_full;
        fifo_out_din   = out_data_q;
        shift_en       = fifo_in_rd_en | (~reset & (state_q == S_FLUSH) & adv);
        load           = ((state_q == S_RUN) & fifo_in_rd_en) |
                         (~reset & (state_q == S_FLUSH) & adv);
        border         = (row_q == '0) | (row_q == ROW_LAST) |
                         (col_q == '0) | (col_q == COL_LAST);
        pixel_in       = (state_q == S_FLUSH) ? '0 : fifo_in_dout;
        sr_shift       = {sr_q[SR_LEN-2:0], pixel_in};
    end

    // The window is taken from the post-shift view so a result is ready on the
    // same edge that reads its bottom-right neighbour.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign win[3*r+c] = sr_shift[window_tap(IMG_WIDTH, r, c)];
        end
    end

    sobel_kernel #(
        .W         (W),
        .THRESHOLD (THRESHOLD)
    ) u_kernel (
        .win    (win),
        .result (kernel_result)
    );

    // Next-state logic for the FSM, counters, line buffer and output register.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        flush_cnt_d = flush_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (fifo_out_wr_en) begin
            out_valid_d = 1'b0;
        end
        if (shift_en) begin
            sr_d = sr_shift;
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = border ? '0 : kernel_result;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            S_FILL: begin
                if (fifo_in_rd_en) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == FILL_LAST) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (fifo_in_rd_en) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == PIX_LAST) begin
                        in_cnt_d = '0;
                        state_d  = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (load) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        flush_cnt_d = '0;
                        col_d       = '0;
                        row_d       = '0;
                        state_d     = S_FILL;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= S_FILL;
            in_cnt_q    <= '0;
            flush_cnt_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            // NOTE: the line buffer is reset like any other state so a fresh frame starts from a known window.
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
